// File: rtl/fetch_queue_pkg.sv
// Front-end shared types: fetch queue entry layout
// and the boot PC shared with the PC generator.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  typedef struct packed {
    logic [28:0] pc_hi;
    logic [63:0] inst;
    logic [1:0]  mask;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers 2-instruction packets
// and feeds decode one instruction per cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [63:0] fetch_inst_i,
  output logic        stall_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] HIGH = FULL - 1'b1;

  fetch_entry_t  r_q [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  fetch_entry_t  w_head;
  fetch_entry_t  w_new;
  logic          w_sel;
  logic          w_push;
  logic          w_pop;
  logic          w_retire;
  logic [1:0]    w_mask_nxt;

  assign w_head = r_q[r_rd];

  // Head slot select; a dead (mask 0) head reads as slot 0
  always_comb begin
    w_sel      = w_head.mask[1] & ~w_head.mask[0];
    w_mask_nxt = w_head.mask;
    w_mask_nxt[w_sel] = 1'b0;
  end

  assign inst_valid_o = (r_cnt != '0);
  assign inst_o       = w_sel ? w_head.inst[63:32]
                              : w_head.inst[31:0];
  assign inst_pc_o    = {w_head.pc_hi, w_sel, 2'b00};
  assign stall_o      = (r_cnt >= HIGH);

  assign w_push   = fetch_valid_i & ~flush_i
                  & (r_cnt < FULL);
  assign w_pop    = inst_valid_o & inst_ready_i;
  assign w_retire = w_pop & (w_mask_nxt == 2'b00);

  // Entry to be written for an accepted packet
  always_comb begin
    w_new.pc_hi = fetch_pc_i[31:3];
    w_new.inst  = fetch_inst_i;
    w_new.mask  = fetch_pc_i[2] ? 2'b10 : 2'b11;
  end

  // Storage array: push writes at wr, pop clears head slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].mask <= 2'b00;
      end
    end else begin
      if (w_pop) begin
        r_q[r_rd].mask <= w_mask_nxt;
      end
      if (w_push) begin
        r_q[r_wr] <= w_new;
      end
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_retire) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_retire})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the 8-byte-aligned PC generator / I-cache and decode. It buffers fetched packets of two 32-bit instructions and serialises them to decode one instruction per cycle. It drops the slot skipped by an unaligned branch target. It back-pressures the PC generator through `stall_o` and empties on redirect.

## Interface
- `DEPTH`, default 4: packet entries; power of two, ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: redirect; driven together with the PC generator's `taken_i`. Empties the queue.
- `fetch_valid_i` in 1: fetch packet present this cycle.
- `fetch_pc_i` in 32: PC the packet was fetched with. Bit 2 selects the start slot; bits [1:0] are ignored.
- `fetch_inst_i` in 64: {inst at +4, inst at +0} of the aligned 8-byte block.
- `stall_o` out 1: to the PC generator's `stall_i`; holds the PC.
- `inst_valid_o` out 1: head instruction valid.
- `inst_o` out 32: head instruction.
- `inst_pc_o` out 32: head instruction PC, bits [1:0] = 0.
- `inst_ready_i` in 1: decode accepts the head instruction.

## Operation
- Entry contents: `pc_hi`[28:0], `inst`[63:0], `mask`[1:0] (one live bit per slot).
- Push condition: `fetch_valid_i` && !`flush_i` && count < DEPTH, with count sampled before any same-cycle retire.
- On push: write the entry at `wr_ptr`, then `wr_ptr`++.
  - `mask` = 2'b10 if `fetch_pc_i[2]`, else 2'b11.
- Packet arriving while count == DEPTH: dropped, with no state change. This is a protocol violation and the bench asserts it never occurs.
- Head slot: `sel` = 0 if `mask[0]`, else 1.
- Head outputs:
  - `inst_o` = `sel` ? `inst[63:32]` : `inst[31:0]`.
  - `inst_pc_o` = {`pc_hi`, `sel`, 2'b00}.
- Pop occurs when `inst_valid_o` && `inst_ready_i`:
  - Clear the head's `mask[sel]`.
  - If the mask becomes 0, retire the entry: `rd_ptr`++ and count--.
- Simultaneous push and retire: count unchanged, and both pointers advance.
- `inst_valid_o` = (count != 0). An entry with mask 0 is never resident.
- `stall_o` = (count ≥ DEPTH−1), combinational from count. This leaves one free entry for the packet in flight when the PC holds.
- `flush_i`:
  - Next cycle: count = 0, `rd_ptr` = `wr_ptr` = 0, and all masks are 0.
  - A same-cycle `fetch_valid_i` packet is discarded.
  - A same-cycle pop is irrelevant.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Arithmetic: `fetch_pc_i[31:3]` is stored unchanged and never incremented here.

## Timing
- Push at edge N: `inst_valid_o` = 1 and `inst_o` = packet slot in cycle N+1.
  - Latency is 1 cycle and there is no bypass path from input to output.
- Pop at edge N: the next slot or next entry is presented in cycle N+1. Throughput is 1 instruction/cycle.
- `stall_o` changes in the cycle after the count crosses DEPTH−2 ↔ DEPTH−1.
- Reset (`rst_n` = 0 at an edge): count, pointers, masks, `pc_hi` and `inst` are all cleared to 0.
  - Outputs after reset: `inst_valid_o` = 0, `stall_o` = 0, `inst_o` = 0, `inst_pc_o` = 0.
  - Reset mid-operation discards all contents in the same manner.
- Flush takes priority over push. Reset takes priority over everything.
- After a flush with `fetch_valid_i` held, the first packet accepted is the one in the cycle after `flush_i`.

## Structure
- Shared package (the existing front-end/bpu package):
  - typedef `fetch_entry_t` {`pc_hi`, `inst`, `mask`}.
  - localparam `RESET_PC` = 32'h1c000000, shared with the PC generator.
- Storage is an array of `fetch_entry_t` indexed by the pointers.
- Count/pointer logic is inline and there are no sub-modules. The array is plain registers; no RAM macro.

## Test plan
- Reset release with `inst_ready_i` = 1 and no fetch → `inst_valid_o` = 0, `stall_o` = 0, `inst_pc_o` = 0.
- Push pc 0x1c000000 with inst {0xBBBBBBBB, 0xAAAAAAAA}, `inst_ready_i` = 1 → cycle+1: 0xAAAAAAAA at pc 0x1c000000; cycle+2: 0xBBBBBBBB at 0x1c000004; cycle+3: `inst_valid_o` = 0.
- Push pc 0x1c000014 (unaligned) → only the upper slot is delivered, at pc 0x1c000014; the entry then retires after 1 pop.
- `inst_ready_i` = 0 with 3 consecutive pushes (DEPTH = 4) → `stall_o` rises the cycle after the 3rd push. A 4th push fills the queue. Releasing ready → 8 instructions in order with contiguous PCs.
- Queue holding 3 entries, `flush_i` with a same-cycle `fetch_valid_i` (pc 0x1c000100) → next cycle `inst_valid_o` = 0, `stall_o` = 0, and the packet is not delivered.
- Simultaneous push and retire at count = DEPTH−1 → count stays DEPTH−1, `stall_o` stays 1, and order is preserved across the pointer wrap.
